// File: rtl/log2_histogram_pkg.sv
// Shared types and sizing for the log2 histogram.
package log2_histogram_pkg;

    localparam int unsigned NUM_BINS  = 8;
    localparam int unsigned BIN_IDX_W = 3;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DUMP  = 2'd1,
        CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/log2_hist_bins.sv
// Bin register file: increment, wrap or saturate, sticky overflow, bulk clear.
// LOG2_HIST_SAT_EN defined: bins hold at all-ones; undefined: bins wrap to 0.
module log2_hist_bins
    import log2_histogram_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_en,
    input  logic [BIN_IDX_W-1:0] inc_idx,
    input  logic                 clr,
    input  logic [BIN_IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0]     rd_count,
    output logic                 ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] bins_q [NUM_BINS];
    logic [CNT_W-1:0] bins_d [NUM_BINS];
    logic             ovf_q;
    logic             ovf_d;

    always_comb begin
        bins_d = bins_q;
        ovf_d  = ovf_q;
        if (clr) begin
            bins_d = '{default: '0};
            ovf_d  = 1'b0;
        end else if (inc_en) begin
`ifdef LOG2_HIST_SAT_EN
            if (bins_q[inc_idx] != CNT_MAX) begin
                bins_d[inc_idx] = bins_q[inc_idx] + CNT_W'(1);
            end
`else
            bins_d[inc_idx] = bins_q[inc_idx] + CNT_W'(1);
`endif
            // Flag the hit that lands a bin on all-ones.
            if (bins_q[inc_idx] == CNT_MAX - CNT_W'(1)) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bins_q <= '{default: '0};
            ovf_q  <= 1'b0;
        end else begin
            bins_q <= bins_d;
            ovf_q  <= ovf_d;
        end
    end

    assign rd_count = bins_q[rd_idx];
    assign ovf      = ovf_q;

endmodule

// File: rtl/log2_histogram.sv
// Log2 histogram: accumulates samples into 8 bins, then reads out and clears them.
// Build option LOG2_HIST_SAT_EN makes bins saturate instead of wrapping.
module log2_histogram
    import log2_histogram_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIN_IDX_W-1:0] log_in,
    input  logic                 dump_req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIN_IDX_W-1:0] out_bin,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_last,
    output logic                 ovf
);

    localparam logic [BIN_IDX_W-1:0] LAST_IDX = BIN_IDX_W'(NUM_BINS - 1);

    state_e               state_q;
    state_e               state_d;
    logic [BIN_IDX_W-1:0] idx_q;
    logic [BIN_IDX_W-1:0] idx_d;
    logic                 inc_en;
    logic                 clr;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ACCUM: begin
                if (dump_req) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            DUMP: begin
                if (out_ready) begin
                    idx_d = idx_q + BIN_IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                state_d = ACCUM;
                idx_d   = '0;
            end
            default: begin
                state_d = ACCUM;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Handshake outputs decode straight from the state flop.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DUMP);
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign out_bin   = idx_q;
    assign inc_en    = in_valid && in_ready;
    assign clr       = (state_q == CLEAR);

    log2_hist_bins #(
        .CNT_W (CNT_W)
    ) u_bins (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (inc_en),
        .inc_idx  (log_in),
        .clr      (clr),
        .rd_idx   (idx_q),
        .rd_count (out_count),
        .ovf      (ovf)
    );

endmodule

// File: tb/tb_log2_histogram.sv
// Scoreboard bench for log2_histogram with 4-bit counters.
module tb_log2_histogram;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    log_in;
    logic          dump_req;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_bin;
    logic [CW-1:0] out_count;
    logic          out_last;
    logic          ovf;

    typedef struct {
        logic [2:0]    bin;
        logic [CW-1:0] cnt;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] model_bins [8];
    logic          model_ovf;
    int            n_total = 0;
    int            n_bad   = 0;

    log2_histogram #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .log_in    (log_in),
        .dump_req  (dump_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_count (out_count),
        .out_last  (out_last),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_hit(input int b);
        logic [CW-1:0] old = model_bins[b];
`ifdef LOG2_HIST_SAT_EN
        if (old != '1) model_bins[b] = old + CW'(1);
`else
        model_bins[b] = old + CW'(1);
`endif
        if (old == CW'(14)) model_ovf = 1'b1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) model_bins[i] = '0;
        model_ovf = 1'b0;
    endfunction

    function automatic void push_dump();
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.bin  = 3'(i);
            e.cnt  = model_bins[i];
            e.last = (i == 7);
            sb.push_back(e);
        end
    endfunction

    // Compare every accepted readout word against the queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_bin", 32'(out_bin), 32'(e.bin));
                check("out_count", 32'(out_count), 32'(e.cnt));
                check("out_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int b);
        in_valid = 1'b1;
        log_in   = 3'(b);
        model_hit(b);
        tick();
        in_valid = 1'b0;
    endtask

    // mode 0: plain readout; 1: stall at bin 2 with a sample held; 2: reset at bin 4.
    task automatic dump(input int mode, input int side_bin);
        bit stalled = 0;
        bit done    = 0;
        dump_req = 1'b1;
        if (side_bin >= 0) begin
            in_valid = 1'b1;
            log_in   = 3'(side_bin);
            model_hit(side_bin);
        end
        push_dump();
        model_clear();
        tick();
        dump_req = 1'b0;
        in_valid = 1'b0;
        check("dump_latency", 32'(out_valid), 1);
        if (mode == 1) begin
            in_valid = 1'b1;
            log_in   = 3'd6;
        end
        for (int c = 0; c < 60 && !done; c++) begin
            if (mode == 1 && !stalled && out_valid && out_bin == 3'd2) begin
                logic [CW-1:0] hold_cnt = sb[0].cnt;
                stalled   = 1;
                out_ready = 1'b0;
                repeat (4) begin
                    tick();
                    check("stall_bin", 32'(out_bin), 2);
                    check("stall_count", 32'(out_count), 32'(hold_cnt));
                    check("stall_valid", 32'(out_valid), 1);
                    check("stall_in_ready", 32'(in_ready), 0);
                end
                out_ready = 1'b1;
            end
            if (mode == 2 && out_valid && out_bin == 3'd4) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                sb.delete();
                model_clear();
                check("rst_out_valid", 32'(out_valid), 0);
                check("rst_in_ready", 32'(in_ready), 1);
                check("rst_out_last", 32'(out_last), 0);
                check("rst_out_bin", 32'(out_bin), 0);
                check("rst_ovf", 32'(ovf), 0);
                return;
            end
            if (out_valid) check("dump_in_ready", 32'(in_ready), 0);
            tick();
            if (sb.size() == 0) done = 1;
        end
        if (!done) begin
            check("dump_timeout", 1, 0);
            return;
        end
        in_valid = 1'b0;
        check("clear_in_ready", 32'(in_ready), 0);
        check("clear_out_valid", 32'(out_valid), 0);
        tick();
        check("accum_in_ready", 32'(in_ready), 1);
        check("cleared_ovf", 32'(ovf), 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        log_in    = '0;
        dump_req  = 1'b0;
        out_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_bin", 32'(out_bin), 0);
        check("reset_out_count", 32'(out_count), 0);
        check("reset_out_last", 32'(out_last), 0);
        check("reset_ovf", 32'(ovf), 0);

        send(0); send(3); send(3); send(7);
        dump(0, -1);

        dump(0, 5);

        send(2); send(2); send(4); send(1);
        dump(1, -1);
        dump(0, -1);

        for (int i = 0; i < 17; i++) send(1);
        check("ovf_set", 32'(ovf), 32'(model_ovf));
        dump(0, -1);

        send(4); send(4); send(1); send(6);
        dump(2, -1);
        dump(0, -1);

        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/log2_histogram.md
LOG2_HISTOGRAM -- requirements
Module: log2_histogram

Interface
REQ-001 Parameter CNT_W, default 16: width of each bin counter.
REQ-002 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port in_valid, input, 1: log_in carries a sample.
REQ-005 Port in_ready, output, 1: block accepts a sample this cycle.
REQ-006 Port log_in, input, 3: log2 value produced by the upstream log2 stage; it is the bin index.
REQ-007 Port dump_req, input, 1: single-cycle request to read out and clear the histogram.
REQ-008 Port out_valid, output, 1: out_bin and out_count are valid.
REQ-009 Port out_ready, input, 1: downstream accepts the current readout word.
REQ-010 Port out_bin, output, 3: bin index of the readout word.
REQ-011 Port out_count, output, CNT_W: count of that bin.
REQ-012 Port out_last, output, 1: high with bin 7.
REQ-013 Port ovf, output, 1: sticky flag; some bin hit its maximum value since the last clear.

Function
REQ-014 The FSM has three states: ACCUM, DUMP and CLEAR. The reset state is ACCUM.
REQ-015 ACCUM: in_ready=1 and out_valid=0. A handshake (in_valid & in_ready) increments bin[log_in] by 1 at the next edge.
REQ-016 ACCUM: dump_req=1 causes a transition to DUMP with the read index set to 0. A sample accepted in the same cycle is counted before readout.
REQ-017 DUMP: in_ready=0. Samples presented in this state are not counted, and the upstream must hold them.
REQ-018 DUMP: out_valid=1, out_bin=index, out_count=bin[index] and out_last=(index==7).
REQ-019 DUMP: out_ready=1 advances the index by 1. out_ready=0 holds all outputs stable.
REQ-020 DUMP: a handshake with out_last=1 causes a transition to CLEAR.
REQ-021 CLEAR lasts exactly one cycle. It zeroes all 8 bins and ovf, forces in_ready=0, then returns to ACCUM.
REQ-022 dump_req is ignored outside ACCUM.
REQ-023 Latency:
- dump_req to first out_valid is 1 cycle.
- A full readout with out_ready held high takes 8 cycles, plus 1 cycle of CLEAR.
REQ-024 Counters are unsigned CNT_W bits. The count is captured combinationally from the bin register; the readout does not modify any bin.
REQ-025 ovf is set at the edge where any bin transitions to all-ones, and stays set until CLEAR or reset.

Reset
REQ-026 rst at any edge, including mid-DUMP, produces:
- state ACCUM and index 0
- all bins 0 and ovf=0
- out_valid=0 and out_last=0
REQ-027 Output values one cycle after reset:
- in_ready=1
- out_bin=0
- out_count=0

Configuration
REQ-028 Macro LOG2_HIST_SAT_EN selects the counter behaviour at all-ones.
- Defined: a bin at all-ones holds its value on further hits.
- Undefined: the bin wraps to 0.
- ovf behaves per REQ-025 in both builds.

Structure
REQ-029 A shared package holds:
- the state typedef (ACCUM, DUMP, CLEAR)
- the constant NUM_BINS=8
- the constant BIN_IDX_W=3
REQ-030 The bin register file and its increment/saturate/clear logic form one sub-module, log2_hist_bins. The FSM and handshake logic stay in the top module.

Verification
REQ-031 Accumulate and dump: feed log_in 0,3,3,7 with in_valid, then pulse dump_req, with out_ready=1. The bench sees 8 words: bin0=1, bin3=2, bin7=1, all others 0, and out_last on bin 7.
REQ-032 Simultaneous request: in_valid with log_in=5 and dump_req in the same cycle. The dump reports bin5=1.
REQ-033 Backpressure: hold out_ready=0 for 4 cycles at bin 2. out_bin=2 and out_count stay stable. in_ready stays 0 throughout DUMP and CLEAR.
REQ-034 Overflow with CNT_W=4: apply 17 hits to bin 1.
- With LOG2_HIST_SAT_EN: count=15 and ovf=1.
- Without it: count=1 and ovf=1.
REQ-035 Reset mid-DUMP: assert rst at bin 4. Next cycle: out_valid=0, in_ready=1, and a following dump reports all bins 0.
